// File: rtl/shift_pkg.sv
// Shared types and constants for the universal shift register (shift_univ).
package shift_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    SER  = 1'b1
  } state_e;

  localparam logic DIR_RIGHT = 1'b0;
  localparam logic DIR_LEFT  = 1'b1;

endpackage

// File: rtl/shift_ctr.sv
// Frame bit counter for shift_univ: clears on frame start, counts serial shifts,
// and flags the shift that completes a WIDTH-bit frame.
module shift_ctr #(
  parameter int WIDTH = 8
) (
  input  logic                         CLK,
  input  logic                         RST,
  input  logic                         CLR,
  input  logic                         INC,
  output logic [$clog2(WIDTH+1)-1:0]   CNT,
  output logic                         LAST
);

  localparam int CW = $clog2(WIDTH+1);

  logic [CW-1:0] cnt_q, cnt_d;

  // NOTE: every combinational output gets a default first, so no path can infer a latch.
  always_comb begin
    cnt_d = cnt_q;
    if (CLR) begin
      cnt_d = '0;
    end else if (INC) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // NOTE: state registers use non-blocking assignment; blocking here would race with readers.
  always_ff @(posedge CLK) begin
    if (RST) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign CNT  = cnt_q;
  // LAST marks the count before the WIDTH-th increment, so the counter tops out at WIDTH.
  assign LAST = (cnt_q == CW'(WIDTH - 1));

endmodule

// File: rtl/shift_univ.sv
// Universal shift register with parallel load, single-step shift and automatic
// serialization. Rotate support is built only when SHIFT_UNIV_ROT_EN is defined.
module shift_univ
  import shift_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             SIN,
  input  logic             SH,
  input  logic             LD,
  input  logic             DIR,
  input  logic             ROT,
  input  logic             START,
  input  logic [WIDTH-1:0] PIN,
  output logic             SOUT,
  output logic [WIDTH-1:0] POUT,
  output logic             BUSY,
  output logic             DONE
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic             dir_q, dir_d;
  logic             done_q, done_d;
  logic             eff_dir, eff_rot;
  logic             ctr_clr, ctr_inc, ctr_last;
  logic [$clog2(WIDTH+1)-1:0] unused_cnt;

  function automatic logic [WIDTH-1:0] shift_step(input logic [WIDTH-1:0] q,
                                                  input logic dir,
                                                  input logic rot,
                                                  input logic sin);
    logic fill;
    if (dir == DIR_LEFT) begin
      fill = rot ? q[WIDTH-1] : sin;
      return {q[WIDTH-2:0], fill};
    end
    fill = rot ? q[0] : sin;
    return {fill, q[WIDTH-1:1]};
  endfunction

  // While serializing, direction and rotate come from the values captured at START.
  assign eff_dir = (state_q == SER) ? dir_q : DIR;

`ifdef SHIFT_UNIV_ROT_EN
  logic rot_q, rot_d;
  assign eff_rot = (state_q == SER) ? rot_q : ROT;
`else
  logic unused_rot;
  assign unused_rot = ROT;
  assign eff_rot    = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    q_d     = q_q;
    dir_d   = dir_q;
`ifdef SHIFT_UNIV_ROT_EN
    rot_d   = rot_q;
`endif
    done_d  = 1'b0;
    ctr_clr = 1'b0;
    ctr_inc = 1'b0;
    case (state_q)
      IDLE: begin
        if (LD) begin
          q_d = PIN;
        end else if (START) begin
          q_d     = PIN;
          dir_d   = DIR;
`ifdef SHIFT_UNIV_ROT_EN
          rot_d   = ROT;
`endif
          ctr_clr = 1'b1;
          state_d = SER;
        end else if (SH) begin
          q_d = shift_step(q_q, eff_dir, eff_rot, SIN);
        end
      end
      SER: begin
        q_d     = shift_step(q_q, eff_dir, eff_rot, SIN);
        ctr_inc = 1'b1;
        if (ctr_last) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      q_q     <= '0;
      dir_q   <= DIR_RIGHT;
`ifdef SHIFT_UNIV_ROT_EN
      rot_q   <= 1'b0;
`endif
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      q_q     <= q_d;
      dir_q   <= dir_d;
`ifdef SHIFT_UNIV_ROT_EN
      rot_q   <= rot_d;
`endif
      done_q  <= done_d;
    end
  end

  shift_ctr #(.WIDTH(WIDTH)) u_ctr (
    .CLK  (CLK),
    .RST  (RST),
    .CLR  (ctr_clr),
    .INC  (ctr_inc),
    .CNT  (unused_cnt),
    .LAST (ctr_last)
  );

  assign POUT = q_q;
  assign BUSY = (state_q == SER);
  assign DONE = done_q;
  assign SOUT = (eff_dir == DIR_LEFT) ? q_q[WIDTH-1] : q_q[0];

endmodule

// File: tb/tb_shift_univ.sv
// Self-checking bench for shift_univ (WIDTH=8): directed scenarios plus random
// stimulus compared each cycle against a behavioural frame-level model.
module tb_shift_univ;

  localparam int W = 8;

  logic         clk, rst, sin, sh, ld, dir, rot, start;
  logic [W-1:0] pin;
  logic         sout, busy, done;
  logic [W-1:0] pout;

  int n_vec = 0;
  int n_bad = 0;

  // Reference model: register value, shifts left in the current frame, pending DONE.
  logic [W-1:0] m_q;
  int           m_left;
  logic         m_done, m_dir, m_rot;

  shift_univ #(.WIDTH(W)) dut (
    .CLK   (clk),
    .RST   (rst),
    .SIN   (sin),
    .SH    (sh),
    .LD    (ld),
    .DIR   (dir),
    .ROT   (rot),
    .START (start),
    .PIN   (pin),
    .SOUT  (sout),
    .POUT  (pout),
    .BUSY  (busy),
    .DONE  (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] ref_shift(input logic [W-1:0] q, input logic left,
                                             input logic r, input logic s);
    logic fill;
    logic rot_on;
`ifdef SHIFT_UNIV_ROT_EN
    rot_on = r;
`else
    rot_on = 1'b0;
`endif
    if (left) begin
      fill = rot_on ? q[W-1] : s;
      return (q << 1) | W'(fill);
    end
    fill = rot_on ? q[0] : s;
    return (q >> 1) | (W'(fill) << (W - 1));
  endfunction

  task automatic model_edge();
    if (rst) begin
      m_q    = '0;
      m_left = 0;
      m_done = 1'b0;
      m_dir  = 1'b0;
      m_rot  = 1'b0;
    end else begin
      m_done = 1'b0;
      if (m_left > 0) begin
        m_q = ref_shift(m_q, m_dir, m_rot, sin);
        m_left--;
        if (m_left == 0) m_done = 1'b1;
      end else if (ld) begin
        m_q = pin;
      end else if (start) begin
        m_q    = pin;
        m_left = W;
        m_dir  = dir;
        m_rot  = rot;
      end else if (sh) begin
        m_q = ref_shift(m_q, dir, rot, sin);
      end
    end
  endtask

  task automatic cycle();
    logic exp_dir;
    @(posedge clk);
    model_edge();
    #1;
    exp_dir = (m_left > 0) ? m_dir : dir;
    check("pout", pout, m_q);
    check("busy", busy, m_left > 0);
    check("done", done, m_done);
    check("sout", sout, exp_dir ? m_q[W-1] : m_q[0]);
  endtask

  task automatic quiet();
    rst = 1'b0; ld = 1'b0; start = 1'b0; sh = 1'b0;
    dir = 1'b0; rot = 1'b0; sin = 1'b0; pin = '0;
  endtask

  initial begin
    logic [W-1:0] a5;
    logic [W-1:0] p2;
    a5 = 8'hA5;

    quiet();
    rst = 1'b1;
    m_q = '0; m_left = 0; m_done = 1'b0; m_dir = 1'b0; m_rot = 1'b0;
    cycle();
    cycle();
    check("rst_pout", pout, 8'h00);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_sout", sout, 1'b0);
    rst = 1'b0;

    // Parallel load and single-step shifts
    ld = 1'b1; pin = 8'd135;
    cycle();
    check("ld_pout", pout, 8'b1000_0111);
    check("ld_sout", sout, 1'b1);
    ld = 1'b0; sh = 1'b1; dir = 1'b0; sin = 1'b0;
    cycle();
    cycle();
    check("shr2_pout", pout, 8'b0010_0001);
    sin = 1'b1; dir = 1'b1;
    cycle();
    check("shl1_pout", pout, 8'b0100_0011);

    // Rotate versus plain shift
    quiet();
    ld = 1'b1; pin = 8'h81;
    cycle();
    ld = 1'b0; sh = 1'b1; dir = 1'b0; rot = 1'b1; sin = 1'b0;
    cycle();
`ifdef SHIFT_UNIV_ROT_EN
    check("rot_pout", pout, 8'hC0);
`else
    check("norot_pout", pout, 8'h40);
`endif

    // Serialize 0xA5 LSB first, with LD noise during the frame
    quiet();
    start = 1'b1; pin = a5;
    cycle();
    start = 1'b0;
    for (int k = 0; k < W; k++) begin
      check("ser_busy", busy, 1'b1);
      check("ser_done", done, 1'b0);
      check("ser_bit", sout, a5[k]);
      ld  = 1'($urandom_range(0, 1));
      sh  = 1'($urandom_range(0, 1));
      sin = 1'($urandom_range(0, 1));
      pin = W'($urandom);
      cycle();
    end
    check("fin_busy", busy, 1'b0);
    check("fin_done", done, 1'b1);
    quiet();
    cycle();
    check("post_done", done, 1'b0);

    // Reset aborts a frame in BUSY cycle 4
    start = 1'b1; pin = W'($urandom); dir = 1'($urandom_range(0, 1));
    cycle();
    start = 1'b0;
    repeat (4) cycle();
    check("abort_busy_before", busy, 1'b1);
    rst = 1'b1;
    cycle();
    check("abort_pout", pout, 8'h00);
    check("abort_busy", busy, 1'b0);
    rst = 1'b0;
    repeat (12) begin
      cycle();
      check("abort_nodone", done, 1'b0);
    end

    // Back-to-back frames: START taken in the DONE cycle
    quiet();
    start = 1'b1; pin = W'($urandom);
    cycle();
    start = 1'b0;
    repeat (W) cycle();
    check("b2b_done1", done, 1'b1);
    p2 = W'($urandom);
    start = 1'b1; pin = p2; dir = 1'b1;
    cycle();
    start = 1'b0;
    check("b2b_busy", busy, 1'b1);
    check("b2b_pout", pout, p2);
    dir = 1'b0;
    for (int k = 0; k < W; k++) begin
      check("b2b_bit", sout, p2[W-1-k]);
      cycle();
    end
    check("b2b_done2", done, 1'b1);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      rst   = ($urandom_range(0, 49) == 0);
      ld    = ($urandom_range(0, 5) == 0);
      start = ($urandom_range(0, 7) == 0);
      sh    = 1'($urandom_range(0, 1));
      dir   = 1'($urandom_range(0, 1));
      rot   = 1'($urandom_range(0, 1));
      sin   = 1'($urandom_range(0, 1));
      pin   = W'($urandom);
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/shift_univ.md
SHIFT_UNIV -- requirements
Module: shift_univ

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, register width in bits (legal range 2..64).
REQ-002 The block SHALL have port CLK  input  1  sole clock; all state updates on its rising edge.
REQ-003 The block SHALL have port RST  input  1  reset, synchronous and active-high.
REQ-004 The block SHALL have port SIN  input  1  serial data in.
REQ-005 The block SHALL have port SH  input  1  single-step shift enable.
REQ-006 The block SHALL have port LD  input  1  parallel load enable.
REQ-007 The block SHALL have port DIR  input  1  shift direction: 0 right (SIN enters MSB), 1 left (SIN enters LSB).
REQ-008 The block SHALL have port ROT  input  1  rotate: the bit shifted out re-enters instead of SIN.
REQ-009 The block SHALL have port START  input  1  begin automatic serialization of PIN.
REQ-010 The block SHALL have port PIN  input  WIDTH  parallel data in.
REQ-011 The block SHALL have port SOUT  output  1  serial out: Q[0] when DIR=0, Q[WIDTH-1] when DIR=1 (DIR latched while BUSY).
REQ-012 The block SHALL have port POUT  output  WIDTH  register contents Q.
REQ-013 The block SHALL have port BUSY  output  1  high while serialization is in progress.
REQ-014 The block SHALL have port DONE  output  1  one-cycle pulse after serialization completes.

Function
REQ-015 The block SHALL implement a two-state FSM: IDLE and SER.
REQ-016 In IDLE the block SHALL apply priority LD > START > SH: LD loads PIN and stays IDLE; START loads PIN and enters SER; SH shifts once per DIR/ROT; otherwise Q holds.
REQ-017 In SER the block SHALL shift once every cycle, using DIR and ROT latched at START, and SHALL ignore LD, SH and START.
REQ-018 A bit counter SHALL clear on START and increment per SER shift; on the WIDTH-th shift the FSM SHALL return to IDLE.
REQ-019 BUSY SHALL be high for exactly WIDTH cycles, starting the cycle after the START edge.
REQ-020 DONE SHALL be registered and high for exactly the one cycle after the final shift; BUSY SHALL be low in that cycle.
REQ-021 START asserted in the DONE cycle SHALL be accepted, giving back-to-back frames with no idle gap.
REQ-022 SOUT SHALL be combinational from Q, so bit k of a frame is present in BUSY cycle k (LSB first when DIR=0).
REQ-023 Counter width SHALL be $clog2(WIDTH+1); wrap-around SHALL NOT occur.

Reset
REQ-024 When RST is high at a rising CLK edge, Q SHALL become 0, the FSM SHALL enter IDLE, the counter SHALL become 0, and BUSY and DONE SHALL become 0; SOUT is therefore 0.
REQ-025 RST SHALL take priority over all other inputs, including mid-serialization; DONE SHALL NOT pulse after an aborted frame.

Configuration
REQ-026 With macro SHIFT_UNIV_ROT_EN defined, the block SHALL honour ROT as specified in REQ-008.
REQ-027 Without SHIFT_UNIV_ROT_EN, the ROT port SHALL remain present, SHALL be ignored, and the block SHALL always shift SIN in.

Structure
REQ-028 Package shift_pkg SHALL hold the FSM state typedef and the DIR_RIGHT/DIR_LEFT constants.
REQ-029 The bit counter SHALL be the sub-module shift_ctr (parameter WIDTH; ports CLK, RST, CLR, INC, CNT, LAST).

Verification (WIDTH=8)
REQ-030 The bench SHALL load PIN=8'd135 with LD=1 -> POUT=10000111, SOUT=1.
REQ-031 The bench SHALL apply SH=1, DIR=0, SIN=0 for two cycles -> POUT=00100001; then SIN=1, DIR=1 for one cycle -> POUT=01000011.
REQ-032 With SHIFT_UNIV_ROT_EN defined, the bench SHALL load 8'h81 and apply SH=1, DIR=0, ROT=1 -> POUT=8'hC0; without the macro the same stimulus with SIN=0 -> POUT=8'h40.
REQ-033 The bench SHALL apply START with PIN=8'hA5, DIR=0 -> SOUT over 8 BUSY cycles is 1,0,1,0,0,1,0,1; DONE is high in the 9th cycle only; LD pulses during BUSY have no effect.
REQ-034 The bench SHALL assert RST in BUSY cycle 4 -> next cycle POUT=0, BUSY=0; DONE stays 0 thereafter.
REQ-035 The bench SHALL assert START in the DONE cycle -> BUSY rises the next cycle and the second frame is serialized with no gap.
